// File: rtl/w25q32jv_burst_reader.sv
// rtl/w25q32jv_burst_reader.sv - burst request sequencer in front of the W25Q32JV fast-read controller
//
// Splits one burst request (start address, count of 2-byte words) into a
// series of 2-byte fast-read transactions and repacks the returned byte
// pairs into a flow-controlled byte stream through a small FIFO.
//
// Ports:
//   clk, arstn                      system clock, asynchronous active-low reset
//   req_valid/req_ready             burst request handshake
//   req_addr[23:0], req_len         start byte address, number of 2-byte words
//   busy, burst_done                burst in progress, one-cycle completion pulse
//   fr_start, fr_addr[23:0]         start pulse and address to the fast-read controller
//   fr_done, fr_data_1, fr_data_2   controller done level and returned bytes (A, A+1)
//   dout_valid/dout_ready           output byte handshake
//   dout_data[7:0], dout_last       output byte, final-byte-of-burst marker
module w25q32jv_burst_reader #(
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             busy,
    output logic             burst_done,
    output logic             fr_start,
    output logic [23:0]      fr_addr,
    input  logic             fr_done,
    input  logic [7:0]       fr_data_1,
    input  logic [7:0]       fr_data_2,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [7:0]       dout_data,
    output logic             dout_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t             state_q, state_d;
    logic [23:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               fr_start_q, fr_start_d;
    logic [23:0]        fr_addr_q, fr_addr_d;
    logic               burst_done_q, burst_done_d;
    logic               fr_done_q, fr_done_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Entry layout: {last, data}
    logic [8:0]         mem_q [FIFO_DEPTH];

    logic               wr_en;
    logic               wr_last;
    logic               rd_en;
    logic               done_rise;
    logic [CNT_W-1:0]   fifo_free;

    assign fifo_free = CNT_W'(FIFO_DEPTH) - count_q;
    assign rd_en     = (count_q != '0) && dout_ready;
    // Registered copy of fr_done makes the capture fire once per transaction
    // even though the controller holds done high for several cycles.
    assign done_rise = fr_done && !fr_done_q;
    assign fr_done_d = fr_done;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        fr_start_d   = 1'b0;
        fr_addr_d    = fr_addr_q;
        burst_done_d = 1'b0;
        wr_en        = 1'b0;
        wr_last      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    rem_d  = req_len;
                    if (req_len == '0) begin
                        burst_done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Room for a whole byte pair guarantees the dual write never overflows.
                if ((fifo_free >= CNT_W'(2)) && !fr_done) begin
                    fr_start_d = 1'b1;
                    fr_addr_d  = addr_q;
                    state_d    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (done_rise) begin
                    wr_en   = 1'b1;
                    wr_last = (rem_q == LEN_W'(1));
                    rem_d   = rem_q - LEN_W'(1);
                    addr_d  = addr_q + 24'd2;
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!fr_done) begin
                    if (rem_q != '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        burst_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(2);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + (wr_en ? CNT_W'(2) : CNT_W'(0)) - (rd_en ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            fr_start_q   <= 1'b0;
            fr_addr_q    <= '0;
            burst_done_q <= 1'b0;
            fr_done_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            fr_start_q   <= fr_start_d;
            fr_addr_q    <= fr_addr_d;
            burst_done_q <= burst_done_d;
            fr_done_q    <= fr_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: the read side is qualified by count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q]              <= {1'b0, fr_data_1};
            mem_q[wr_ptr_q + PTR_W'(1)]  <= {wr_last, fr_data_2};
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign burst_done = burst_done_q;
    assign fr_start   = fr_start_q;
    assign fr_addr    = fr_addr_q;
    assign dout_valid = (count_q != '0);
    assign dout_data  = dout_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign dout_last  = dout_valid ? mem_q[rd_ptr_q][8] : 1'b0;

endmodule
